// File: rtl/setup_serializer_if.sv
// Setup-word handshake bundle: data_in/valid_in from the feeder side,
// ready_out back from the serializer queue.
interface setup_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/setup_serializer.sv
// Setup-word serializer: 2-entry queue feeding an LSB-first bit stream.
// Ports: clk_in, rst_in (async, low), clear_in (sync flush), s_if
// (data/valid/ready), serial_out, en_out, done_out, busy_out.
module setup_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  setup_serializer_if.slave s_if,
  output logic serial_out,
  output logic en_out,
  output logic done_out,
  output logic busy_out
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t r_state, w_state;

  logic [WIDTH-1:0] r_q [2];
  logic             r_wp, r_rp;
  logic [1:0]       r_cnt;

  logic [WIDTH-1:0] r_sh, w_sh;
  logic [BW-1:0]    r_bit, w_bit;
  logic [3:0]       r_gap, w_gap;
  logic             r_en, w_en;
  logic             r_ser, w_ser;
  logic             r_done, w_done;
  logic             r_busy;

  logic             w_push, w_pop, w_load, w_avail;
  logic [WIDTH-1:0] w_head;

  assign s_if.ready_out = (r_cnt != 2'd2);
  assign w_push  = s_if.valid_in && s_if.ready_out && !clear_in;
  assign w_avail = (r_cnt != 2'd0);
  assign w_head  = r_q[r_rp];

  always_comb begin
    w_state = r_state;
    w_sh    = r_sh;
    w_bit   = r_bit;
    w_gap   = r_gap;
    w_en    = 1'b0;
    w_ser   = 1'b0;
    w_done  = 1'b0;
    w_load  = 1'b0;
    w_pop   = 1'b0;
    if (clear_in) begin
      w_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_load = w_avail;
        end
        S_SHIFT: begin
          if (r_bit == BW'(WIDTH-1)) begin
            w_done = 1'b1;
            if (GAP_CYCLES == 0 && w_avail) begin
              w_load = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              w_state = S_GAP;
              w_gap   = 4'd0;
            end else begin
              w_state = S_IDLE;
            end
          end else begin
            w_en  = 1'b1;
            w_ser = r_sh[0];
            w_sh  = r_sh >> 1;
            w_bit = r_bit + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == 4'(GAP_CYCLES-1)) begin
            if (w_avail) w_load = 1'b1;
            else         w_state = S_IDLE;
          end else begin
            w_gap = r_gap + 4'd1;
          end
        end
        default: w_state = S_IDLE;
      endcase
      // r_sh keeps only the bits not yet presented
      if (w_load) begin
        w_pop   = 1'b1;
        w_state = S_SHIFT;
        w_en    = 1'b1;
        w_ser   = w_head[0];
        w_sh    = w_head >> 1;
        w_bit   = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_en    <= 1'b0;
      r_ser   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sh    <= w_sh;
      r_bit   <= w_bit;
      r_gap   <= w_gap;
      r_en    <= w_en;
      r_ser   <= w_ser;
      r_done  <= w_done;
      r_busy  <= (w_state != S_IDLE);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (clear_in) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_q[r_wp] <= s_if.data_in;
  end

  assign serial_out = r_ser;
  assign en_out     = r_en;
  assign done_out   = r_done;
  assign busy_out   = r_busy;

endmodule

// File: tb/tb_setup_serializer.sv
// Bench for setup_serializer: GAP_CYCLES=0 and =1 instances driven
// together, checked against a word-schedule reference model.
module tb_setup_serializer;

  localparam int W = 8;
  localparam int N = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  setup_serializer_if #(.WIDTH(W)) bus0 ();
  setup_serializer_if #(.WIDTH(W)) bus1 ();

  logic [1:0] ser_o, en_o, done_o, busy_o;

  setup_serializer #(.WIDTH(W), .GAP_CYCLES(0)) u0 (
    .clk_in(clk), .rst_in(rst_n), .clear_in(clr), .s_if(bus0),
    .serial_out(ser_o[0]), .en_out(en_o[0]),
    .done_out(done_o[0]), .busy_out(busy_o[0])
  );

  setup_serializer #(.WIDTH(W), .GAP_CYCLES(1)) u1 (
    .clk_in(clk), .rst_in(rst_n), .clear_in(clr), .s_if(bus1),
    .serial_out(ser_o[1]), .en_out(en_o[1]),
    .done_out(done_o[1]), .busy_out(busy_o[1])
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int         gp [2];
  logic [7:0] mw [2][N];
  int         ms [2][N];
  int         mh [2];
  int         mn [2];
  int         ls [2];
  logic [7:0] ds [2];

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? bus0.ready_out : bus1.ready_out;
  endfunction

  function automatic void m_clear(input int k);
    mh[k] = mn[k];
    ls[k] = -1000;
  endfunction

  // A word accepted at edge E starts at max(E+1, prev_start+W+gap);
  // the queue holds accepted words whose start edge is still ahead.
  function automatic void m_edge(input int k, input logic v,
                                 input logic [7:0] d, input logic c);
    int q;
    int s;
    if (c) begin
      m_clear(k);
      return;
    end
    q = 0;
    for (int i = mh[k]; i < mn[k]; i++)
      if (ms[k][i % N] >= cyc) q++;
    if (v && q < 2) begin
      s = cyc + 1;
      if (ls[k] + W + gp[k] > s) s = ls[k] + W + gp[k];
      ms[k][mn[k] % N] = s;
      mw[k][mn[k] % N] = d;
      mn[k]++;
      ls[k] = s;
    end
    while (mh[k] < mn[k] && ms[k][mh[k] % N] + W + 16 < cyc)
      mh[k]++;
  endfunction

  task automatic m_chk(input int k);
    logic       e_en, e_ser, e_done, e_busy;
    logic [7:0] e_word, wd;
    logic [2:0] bi;
    int         q, s, j;
    e_en = 0; e_ser = 0; e_done = 0; e_busy = 0;
    e_word = '0; q = 0;
    for (int i = mh[k]; i < mn[k]; i++) begin
      j  = i % N;
      s  = ms[k][j];
      wd = mw[k][j];
      if (cyc >= s && cyc <= s + W - 1) begin
        bi    = 3'(cyc - s);
        e_en  = 1'b1;
        e_ser = wd[bi];
      end
      if (cyc == s + W) begin
        e_done = 1'b1;
        e_word = wd;
      end
      if (cyc >= s && cyc <= s + W + gp[k] - 1) e_busy = 1'b1;
      if (s > cyc) q++;
    end
    chk($sformatf("en%0d", k),    8'(en_o[k]),   8'(e_en));
    chk($sformatf("ser%0d", k),   8'(ser_o[k]),  8'(e_ser));
    chk($sformatf("done%0d", k),  8'(done_o[k]), 8'(e_done));
    chk($sformatf("busy%0d", k),  8'(busy_o[k]), 8'(e_busy));
    chk($sformatf("ready%0d", k), 8'(rdy(k)),    8'(q < 2));
    if (e_done) chk($sformatf("word%0d", k), ds[k], e_word);
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic c);
    logic [1:0] pe, ps;
    bus0.valid_in = v;
    bus0.data_in  = d;
    bus1.valid_in = v;
    bus1.data_in  = d;
    clr = c;
    pe = en_o;
    ps = ser_o;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (pe[k]) ds[k] = {ps[k], ds[k][7:1]};
      m_edge(k, v, d, c);
    end
    #1;
    for (int k = 0; k < 2; k++) m_chk(k);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_en%0d", tag, k),   8'(en_o[k]),   8'd0);
      chk($sformatf("%s_ser%0d", tag, k),  8'(ser_o[k]),  8'd0);
      chk($sformatf("%s_done%0d", tag, k), 8'(done_o[k]), 8'd0);
      chk($sformatf("%s_busy%0d", tag, k), 8'(busy_o[k]), 8'd0);
      chk($sformatf("%s_rdy%0d", tag, k),  8'(rdy(k)),    8'd1);
    end
  endtask

  initial begin
    gp[0] = 0;
    gp[1] = 1;
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0;
      mn[k] = 0;
      ls[k] = -1000;
      ds[k] = '0;
    end
    bus0.valid_in = 1'b0;
    bus0.data_in  = '0;
    bus1.valid_in = 1'b0;
    bus1.data_in  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    #2 rst_n = 1'b1;
    #2;

    step(1'b1, 8'hA5, 1'b0);
    idle(12);

    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    idle(30);

    step(1'b1, 8'h81, 1'b0);
    step(1'b1, 8'h7E, 1'b0);
    idle(22);

    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    repeat (12) step(1'b1, 8'h55, 1'b0);
    idle(40);

    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    idle(4);
    step(1'b0, 8'h00, 1'b1);
    idle(12);

    step(1'b1, 8'h96, 1'b0);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("arst");
    m_clear(0);
    m_clear(1);
    #1 rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    idle(12);

    repeat (400)
      step(logic'($urandom_range(0, 1)), 8'($urandom),
           logic'($urandom_range(0, 49) == 0));
    idle(24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
